// File: rtl/ip_amba_ahb5_pkg.sv
// Shared AHB5 encodings, responder FSM states and byte-lane strobe helper.
package ip_amba_ahb5_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_state_e;

  function automatic logic trans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: trans_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  trans_active = 1'b0;
      default:                   trans_active = 1'b0;
    endcase
  endfunction

  // Little-endian lane map; only meaningful for aligned, legal sizes.
  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: lane_strb = 4'b0001 << off;
      HSIZE_HALF: lane_strb = off[1] ? 4'b1100 : 4'b0011;
      default:    lane_strb = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ip_amba_ahb5_excl_monitor.sv
// One-entry exclusive-access monitor {valid, master, word index}.
module ip_amba_ahb5_excl_monitor #(
  parameter int unsigned AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          wr_commit_i,
  input  logic [3:0]    master_i,
  input  logic [AW-1:0] idx_i,
  output logic          match_o
);

  logic          valid_q;
  logic [3:0]    master_q;
  logic [AW-1:0] idx_q;
  logic          hits_idx;

  assign hits_idx = valid_q && (idx_q == idx_i);
  assign match_o  = hits_idx && (master_q == master_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      master_q <= '0;
      idx_q    <= '0;
    end else if (load_i) begin
      valid_q  <= 1'b1;
      master_q <= master_i;
      idx_q    <= idx_i;
    end else if (wr_commit_i && hits_idx) begin
      valid_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/ip_amba_ahb5_wait_state_slave.sv
// AHB5 responder: word register array with programmable wait states.
// Optional exclusive-access support under IP_AMBA_AHB5_SLAVE_EXCL_EN.
module ip_amba_ahb5_wait_state_slave
  import ip_amba_ahb5_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
`ifdef IP_AMBA_AHB5_SLAVE_EXCL_EN
  input  logic        HEXCL,
  input  logic [3:0]  HMASTER,
  output logic        HEXOKAY,
`endif
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW = $clog2(DEPTH);

  ahb_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          active_q, active_d;
  logic [31:0]   mem_q [DEPTH];

  logic          capture, addr_err, done, commit;
  logic [3:0]    strb;
  logic          unused_hburst;

  assign unused_hburst = ^HBURST;
  assign capture = HSEL && HREADY && trans_active(HTRANS);
  assign addr_err = (HSIZE > HSIZE_WORD)
                 || ((HSIZE == HSIZE_HALF) && HADDR[0])
                 || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00))
                 || (HADDR[31:AW+2] != '0);
  // A pending OKAY access completes in the first IDLE-state cycle after capture/WAIT.
  assign done = (state_q == ST_IDLE) && active_q;
  assign strb = lane_strb(size_q, off_q);

`ifdef IP_AMBA_AHB5_SLAVE_EXCL_EN
  logic       excl_q, excl_d;
  logic [3:0] master_q, master_d;
  logic       mon_match;

  ip_amba_ahb5_excl_monitor #(.AW(AW)) u_excl_monitor (
    .clk_i       (HCLK),
    .rst_i       (HRESET),
    .load_i      (done && !write_q && excl_q),
    .wr_commit_i (commit),
    .master_i    (master_q),
    .idx_i       (idx_q),
    .match_o     (mon_match)
  );

  assign commit  = done && write_q && (!excl_q || mon_match);
  assign HEXOKAY = done && excl_q && (!write_q || mon_match);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      excl_q   <= 1'b0;
      master_q <= '0;
    end else begin
      excl_q   <= excl_d;
      master_q <= master_d;
    end
  end

  always_comb begin
    excl_d   = excl_q;
    master_d = master_q;
    if ((state_q == ST_IDLE || state_q == ST_ERR2) && capture) begin
      excl_d   = HEXCL;
      master_d = HMASTER;
    end
  end
`else
  assign commit = done && write_q;
`endif

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      write_q  <= write_d;
      active_q <= active_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (strb[b]) mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    off_d    = off_q;
    size_d   = size_q;
    write_d  = write_q;
    active_d = active_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE and ERR2 both drive HREADYOUT=1, so either may take a new address phase.
        if (HREADY) begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
          if (capture) begin
            idx_d   = HADDR[AW+1:2];
            off_d   = HADDR[1:0];
            size_d  = HSIZE;
            write_d = HWRITE;
            if (addr_err) begin
              state_d = ST_ERR1;
            end else begin
              active_d = 1'b1;
              if (WAIT_STATES != 0) begin
                state_d = ST_WAIT;
                cnt_d   = 4'(WAIT_STATES);
              end
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: if (active_q && !write_q) HRDATA = mem_q[idx_q];
    endcase
  end

endmodule
